// File: rtl/pipe_skid_stage_if.sv
// ============================================================================
// Module   : pipe_skid_stage_if
// Purpose  : valid/ready/data handshake bundle used on both sides of the stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_skid_stage_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : two-entry skid buffer with registered in_ready; optional stall
//            counter enabled by the PIPE_STALL_CNT_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_skid_stage_if.slave        up,
  pipe_skid_stage_if.master       dn
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              emit;

  assign accept = up.valid & in_ready_q;
  assign emit   = out_valid_q & dn.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = up.data;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && emit) begin
            main_d = up.data;
          end else if (accept) begin
            skid_d  = up.data;
            state_d = ST_FULL;
          end else if (emit) begin
            main_d  = NOP_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path can fire
          if (emit) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign up.ready = in_ready_q;
  assign dn.valid = out_valid_q;
  assign dn.data  = out_valid_q ? main_q : NOP_VALUE;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid_q && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a queue model predicts occupancy,
// handshake outputs and data order; directed cases cover reset, flush, sweep.
`default_nettype none

module tb_pipe_skid_stage;
  localparam int          AW     = 32;
  localparam logic [31:0] A_NOP  = 32'h0;
  localparam int          BW     = 8;
  localparam logic [7:0]  B_NOP  = 8'hFF;
  localparam int          TB_CW  = 4;

  logic clk = 1'b0;
  logic rst;
  logic a_flush;
  logic b_flush;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(AW)) a_up ();
  pipe_skid_stage_if #(.DATA_W(AW)) a_dn ();
  pipe_skid_stage_if #(.DATA_W(BW)) b_up ();
  pipe_skid_stage_if #(.DATA_W(BW)) b_dn ();

`ifdef PIPE_STALL_CNT_EN
  logic [TB_CW-1:0] a_stall;
  logic [TB_CW-1:0] b_stall;
  logic [TB_CW-1:0] exp_stall;
`endif

  pipe_skid_stage #(
    .DATA_W(AW), .NOP_VALUE(A_NOP)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W(TB_CW)
`endif
  ) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .up(a_up), .dn(a_dn)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  pipe_skid_stage #(
    .DATA_W(BW), .NOP_VALUE(B_NOP)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W(TB_CW)
`endif
  ) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .up(b_up), .dn(b_dn)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb[$];

  // Model: queue depth is the stage occupancy; head is what out_data must show.
  always @(negedge clk) begin
    logic acc;
    logic emt;
    if (rst) begin
      sb.delete();
`ifdef PIPE_STALL_CNT_EN
      exp_stall = '0;
`endif
    end
    chk("out_valid", {63'd0, a_dn.valid}, {63'd0, sb.size() != 0});
    chk("in_ready", {63'd0, a_up.ready}, {63'd0, sb.size() < 2});
    chk("out_data", {32'd0, a_dn.data}, {32'd0, (sb.size() != 0) ? sb[0] : A_NOP});
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt", {60'd0, a_stall}, {60'd0, exp_stall});
`endif
    if (!rst) begin
      acc = a_up.valid && (sb.size() < 2);
      emt = (sb.size() != 0) && a_dn.ready;
`ifdef PIPE_STALL_CNT_EN
      if ((sb.size() != 0) && !a_dn.ready && (exp_stall != {TB_CW{1'b1}}))
        exp_stall = exp_stall + 1'b1;
`endif
      if (a_flush) begin
        sb.delete();
      end else begin
        if (emt) void'(sb.pop_front());
        if (acc) sb.push_back(a_up.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_flush = 1'b0;  b_flush = 1'b0;
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    repeat (2) cyc();
    chk("rst_a_valid", {63'd0, a_dn.valid}, 64'd0);
    chk("rst_a_ready", {63'd0, a_up.ready}, 64'd1);
    chk("rst_a_data", {32'd0, a_dn.data}, 64'd0);
    chk("rst_b_data", {56'd0, b_dn.data}, 64'hFF);
    rst = 1'b0;
    cyc();

    // Back-to-back stream at full rate
    a_dn.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_up.valid = 1'b1;
      a_up.data  = 32'h11 * i;
      cyc();
      chk("stream_valid", {63'd0, a_dn.valid}, 64'd1);
      chk("stream_data", {32'd0, a_dn.data}, 64'h11 * i);
      chk("stream_ready", {63'd0, a_up.ready}, 64'd1);
    end
    a_up.valid = 1'b0;
    repeat (2) cyc();
    chk("stream_idle", {63'd0, a_dn.valid}, 64'd0);

    // Backpressure: two accepted, third waits upstream
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'hA1;
    cyc();
    a_up.data = 32'hA2;
    cyc();
    chk("bp_full_ready", {63'd0, a_up.ready}, 64'd0);
    a_up.data = 32'hA3;
    repeat (3) cyc();
    chk("bp_hold_ready", {63'd0, a_up.ready}, 64'd0);
    chk("bp_hold_data", {32'd0, a_dn.data}, 64'hA1);
    a_dn.ready = 1'b1;
    cyc();
    chk("bp_out2", {32'd0, a_dn.data}, 64'hA2);
    cyc();
    chk("bp_out3", {32'd0, a_dn.data}, 64'hA3);
    a_up.valid = 1'b0;
    cyc();
    chk("bp_drained", {63'd0, a_dn.valid}, 64'd0);

    // Flush while FULL with a word offered
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'h1;
    cyc();
    a_up.data = 32'h2;
    cyc();
    a_up.data = 32'hBEEF; a_flush = 1'b1;
    cyc();
    a_flush = 1'b0; a_up.valid = 1'b0;
    chk("flush_valid", {63'd0, a_dn.valid}, 64'd0);
    chk("flush_data", {32'd0, a_dn.data}, 64'd0);
    chk("flush_ready", {63'd0, a_up.ready}, 64'd1);
    a_dn.ready = 1'b1;
    repeat (3) cyc();
    chk("flush_no_beef", {63'd0, a_dn.valid}, 64'd0);

    // Asynchronous reset while FULL
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'h5;
    cyc();
    a_up.data = 32'h6;
    cyc();
    a_up.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, a_dn.valid}, 64'd0);
    chk("arst_ready", {63'd0, a_up.ready}, 64'd1);
    chk("arst_data", {32'd0, a_dn.data}, 64'd0);
    cyc();
    rst = 1'b0;
    a_dn.ready = 1'b1;
    a_up.valid = 1'b1; a_up.data = 32'h77;
    cyc();
    a_up.valid = 1'b0;
    chk("post_rst_data", {32'd0, a_dn.data}, 64'h77);
    cyc();

    // Random traffic with occasional flush; the scoreboard checks every cycle
    for (int i = 0; i < 400; i++) begin
      a_up.valid = 1'($urandom_range(0, 1));
      a_up.data  = $urandom;
      a_dn.ready = ($urandom_range(0, 3) != 0);
      a_flush    = ($urandom_range(0, 31) == 0);
      cyc();
    end
    a_flush = 1'b0; a_up.valid = 1'b0; a_dn.ready = 1'b1;
    repeat (4) cyc();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    // Narrow instance with non-zero NOP value
    chk("sweep_idle", {56'd0, b_dn.data}, 64'hFF);
    b_up.valid = 1'b1; b_up.data = 8'h5A;
    cyc();
    b_up.valid = 1'b0;
    chk("sweep_valid", {63'd0, b_dn.valid}, 64'd1);
    chk("sweep_data", {56'd0, b_dn.data}, 64'h5A);
    b_dn.ready = 1'b1;
    cyc();
    chk("sweep_nop", {56'd0, b_dn.data}, 64'hFF);

`ifdef PIPE_STALL_CNT_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'h9;
    cyc();
    a_up.valid = 1'b0;
    repeat (20) cyc();
    chk("stall_sat", {60'd0, a_stall}, 64'd15);
    a_flush = 1'b1;
    cyc();
    a_flush = 1'b0;
    chk("stall_flush", {60'd0, a_stall}, 64'd15);
    rst = 1'b1;
    #1;
    chk("stall_rst", {60'd0, a_stall}, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
